// File: rtl/iob_fifo_sync_asym_pkg.sv
// Shared definitions for the asymmetric synchronous FIFO.
//
// Purpose:
//   - IOB_MAX / IOB_MIN macros, so the wrapper, the bank mapper and any
//     bench can derive MAXDATA_W / MINDATA_W in exactly the same way.
//   - The width-ratio mode enum and small constant functions that derive the
//     bank count and the bank address width from the user parameters.
// Ports: none (package only).

`ifndef IOB_MAX
`define IOB_MAX(a, b) (((a) > (b)) ? (a) : (b))
`endif

`ifndef IOB_MIN
`define IOB_MIN(a, b) (((a) < (b)) ? (a) : (b))
`endif

package iob_fifo_sync_asym_pkg;

    // Which side of the FIFO is the wide one. Selects the bank mapping.
    typedef enum logic [1:0] {
        ASYM_EQUAL  = 2'd0,
        ASYM_W_WIDE = 2'd1,
        ASYM_R_WIDE = 2'd2
    } asym_mode_e;

    function automatic asym_mode_e asym_mode(input int w_data_w, input int r_data_w);
        if (w_data_w > r_data_w) begin
            return ASYM_W_WIDE;
        end else if (r_data_w > w_data_w) begin
            return ASYM_R_WIDE;
        end
        return ASYM_EQUAL;
    endfunction

    // Number of MINDATA_W-wide banks needed to hold one maximum-width word.
    function automatic int bank_count(input int w_data_w, input int r_data_w);
        return `IOB_MAX(w_data_w, r_data_w) / `IOB_MIN(w_data_w, r_data_w);
    endfunction

    // Address width of each individual bank.
    function automatic int bank_addr_w(input int addr_w, input int w_data_w, input int r_data_w);
        return addr_w - $clog2(bank_count(w_data_w, r_data_w));
    endfunction

endpackage

// File: rtl/iob_ram_2p_asym.sv
// Bank mapper between the FIFO pointers and N external MINDATA_W-wide
// dual-port RAM banks.
//
// Purpose:
//   Splits the FIFO write/read pointers into per-bank addresses and lane
//   selects, fans write data out to the banks and muxes/concatenates the bank
//   read data into one read word. The RAM itself lives outside this module.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   w_en_i             accepted write (already gated by w_full)
//   w_addr_i           FIFO write pointer (W_ADDR_W bits)
//   w_data_i           write word (W_DATA_W bits)
//   r_en_i             accepted read (already gated by r_empty)
//   r_addr_i           FIFO read pointer (R_ADDR_W bits)
//   ext_mem_*_o/_i     per-bank RAM interface, read data registered by RAM
//   r_data_o           read word (R_DATA_W bits), valid cycle after r_en_i

module iob_ram_2p_asym
    import iob_fifo_sync_asym_pkg::*;
#(
    parameter  int W_DATA_W  = 32,
    parameter  int R_DATA_W  = 8,
    parameter  int ADDR_W    = 4,
    localparam int MAXDATA_W = `IOB_MAX(W_DATA_W, R_DATA_W),
    localparam int MINDATA_W = `IOB_MIN(W_DATA_W, R_DATA_W),
    localparam int N         = MAXDATA_W / MINDATA_W,
    localparam int MINADDR_W = ADDR_W - $clog2(N),
    localparam int W_ADDR_W  = (W_DATA_W == MAXDATA_W) ? MINADDR_W : ADDR_W,
    localparam int R_ADDR_W  = (R_DATA_W == MAXDATA_W) ? MINADDR_W : ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      w_en_i,
    input  logic [W_ADDR_W-1:0]       w_addr_i,
    input  logic [W_DATA_W-1:0]       w_data_i,
    input  logic                      r_en_i,
    input  logic [R_ADDR_W-1:0]       r_addr_i,
    output logic [N-1:0]              ext_mem_w_en_o,
    output logic [N*MINADDR_W-1:0]    ext_mem_w_addr_o,
    output logic [N*MINDATA_W-1:0]    ext_mem_w_data_o,
    output logic                      ext_mem_r_en_o,
    output logic [N*MINADDR_W-1:0]    ext_mem_r_addr_o,
    input  logic [N*MINDATA_W-1:0]    ext_mem_r_data_i,
    output logic [R_DATA_W-1:0]       r_data_o
);

    localparam int         LOG2N = $clog2(N);
    localparam asym_mode_e MODE  = asym_mode(W_DATA_W, R_DATA_W);

    // Banks only read on an accepted read, so their registered outputs hold
    // the last word until the next accepted read.
    assign ext_mem_r_en_o = r_en_i;

    generate
        if (MODE == ASYM_W_WIDE) begin : g_w_wide
            // One write fills every bank at the same row; the read pointer's
            // low bits pick the lane, its high bits the row.
            logic [LOG2N-1:0] lane_sel_q;

            // Lane select is captured with the read so it lines up with the
            // bank data that appears one cycle later, and is held with it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_sel_q <= '0;
                end else if (r_en_i) begin
                    lane_sel_q <= r_addr_i[LOG2N-1:0];
                end
            end

            assign ext_mem_w_en_o   = {N{w_en_i}};
            assign ext_mem_w_addr_o = {N{w_addr_i}};
            assign ext_mem_w_data_o = w_data_i;
            assign ext_mem_r_addr_o = {N{r_addr_i[R_ADDR_W-1 -: MINADDR_W]}};
            assign r_data_o         = ext_mem_r_data_i[int'(lane_sel_q)*MINDATA_W +: MINDATA_W];
        end else if (MODE == ASYM_R_WIDE) begin : g_r_wide
            // Narrow writes go round-robin across banks (low pointer bits pick
            // the bank), so one row across all banks forms a full read word
            // with the oldest narrow word in bank 0.
            logic [LOG2N-1:0] w_bank;
            logic             unused_clk_rst;

            assign unused_clk_rst = clk ^ rst;
            assign w_bank         = w_addr_i[LOG2N-1:0];

            always_comb begin
                ext_mem_w_en_o         = '0;
                ext_mem_w_en_o[w_bank] = w_en_i;
            end

            assign ext_mem_w_addr_o = {N{w_addr_i[W_ADDR_W-1 -: MINADDR_W]}};
            assign ext_mem_w_data_o = {N{w_data_i}};
            assign ext_mem_r_addr_o = {N{r_addr_i}};
            assign r_data_o         = ext_mem_r_data_i;
        end else begin : g_equal
            logic unused_clk_rst;

            assign unused_clk_rst   = clk ^ rst;
            assign ext_mem_w_en_o   = w_en_i;
            assign ext_mem_w_addr_o = w_addr_i;
            assign ext_mem_w_data_o = w_data_i;
            assign ext_mem_r_addr_o = r_addr_i;
            assign r_data_o         = ext_mem_r_data_i;
        end
    endgenerate

endmodule

// File: rtl/iob_fifo_sync_asym.sv
// Single-clock FIFO with independent write and read widths.
//
// Purpose:
//   Keeps the write/read pointers, the occupancy level (in MINDATA_W units)
//   and the registered full/empty flags, gates requests into accepted
//   operations, and drives external RAM banks through iob_ram_2p_asym.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   ext_mem_*         N external MINDATA_W x 2^MINADDR_W dual-port banks
//   w_en, w_data      write request and W_DATA_W word; dropped when w_full
//   w_full            fewer than W_DATA_W/MINDATA_W free units
//   r_en              read request; dropped when r_empty
//   r_data            R_DATA_W word, valid the cycle after an accepted read
//   r_empty           fewer than R_DATA_W/MINDATA_W stored units
//   level             occupancy in MINDATA_W units (0 .. 2^ADDR_W)

module iob_fifo_sync_asym
    import iob_fifo_sync_asym_pkg::*;
#(
    parameter  int W_DATA_W  = 32,
    parameter  int R_DATA_W  = 8,
    parameter  int ADDR_W    = 4,
    localparam int MAXDATA_W = `IOB_MAX(W_DATA_W, R_DATA_W),
    localparam int MINDATA_W = `IOB_MIN(W_DATA_W, R_DATA_W),
    localparam int N         = MAXDATA_W / MINDATA_W,
    localparam int MINADDR_W = ADDR_W - $clog2(N),
    localparam int W_ADDR_W  = (W_DATA_W == MAXDATA_W) ? MINADDR_W : ADDR_W,
    localparam int R_ADDR_W  = (R_DATA_W == MAXDATA_W) ? MINADDR_W : ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic [N-1:0]              ext_mem_w_en,
    output logic [N*MINADDR_W-1:0]    ext_mem_w_addr,
    output logic [N*MINDATA_W-1:0]    ext_mem_w_data,
    output logic                      ext_mem_r_en,
    output logic [N*MINADDR_W-1:0]    ext_mem_r_addr,
    input  logic [N*MINDATA_W-1:0]    ext_mem_r_data,
    input  logic                      w_en,
    input  logic [W_DATA_W-1:0]       w_data,
    output logic                      w_full,
    input  logic                      r_en,
    output logic [R_DATA_W-1:0]       r_data,
    output logic                      r_empty,
    output logic [ADDR_W:0]           level
);

    localparam int LVL_W = ADDR_W + 1;

    // Units consumed/freed per operation, and the level above which a whole
    // write word would no longer fit.
    localparam logic [LVL_W-1:0] W_INC    = LVL_W'(W_DATA_W / MINDATA_W);
    localparam logic [LVL_W-1:0] R_INC    = LVL_W'(R_DATA_W / MINDATA_W);
    localparam logic [LVL_W-1:0] FULL_THR = LVL_W'((1 << ADDR_W) - (W_DATA_W / MINDATA_W));

    logic [W_ADDR_W-1:0] w_ptr_q, w_ptr_d;
    logic [R_ADDR_W-1:0] r_ptr_q, r_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                w_full_q, w_full_d;
    logic                r_empty_q, r_empty_d;
    logic                acc_w, acc_r;

    assign acc_w = w_en & ~w_full_q;
    assign acc_r = r_en & ~r_empty_q;

    // Both operations may land in the same cycle; the flags are computed from
    // the post-update level so they are correct in the very next cycle.
    always_comb begin
        w_ptr_d = w_ptr_q;
        r_ptr_d = r_ptr_q;
        level_d = level_q;
        if (acc_w) begin
            w_ptr_d = w_ptr_q + W_ADDR_W'(1);
            level_d = level_d + W_INC;
        end
        if (acc_r) begin
            r_ptr_d = r_ptr_q + R_ADDR_W'(1);
            level_d = level_d - R_INC;
        end
        w_full_d  = (level_d > FULL_THR);
        r_empty_d = (level_d < R_INC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr_q   <= '0;
            r_ptr_q   <= '0;
            level_q   <= '0;
            w_full_q  <= 1'b0;
            r_empty_q <= 1'b1;
        end else begin
            w_ptr_q   <= w_ptr_d;
            r_ptr_q   <= r_ptr_d;
            level_q   <= level_d;
            w_full_q  <= w_full_d;
            r_empty_q <= r_empty_d;
        end
    end

    assign w_full  = w_full_q;
    assign r_empty = r_empty_q;
    assign level   = level_q;

    iob_ram_2p_asym #(
        .W_DATA_W (W_DATA_W),
        .R_DATA_W (R_DATA_W),
        .ADDR_W   (ADDR_W)
    ) u_ram (
        .clk              (clk),
        .rst              (rst),
        .w_en_i           (acc_w),
        .w_addr_i         (w_ptr_q),
        .w_data_i         (w_data),
        .r_en_i           (acc_r),
        .r_addr_i         (r_ptr_q),
        .ext_mem_w_en_o   (ext_mem_w_en),
        .ext_mem_w_addr_o (ext_mem_w_addr),
        .ext_mem_w_data_o (ext_mem_w_data),
        .ext_mem_r_en_o   (ext_mem_r_en),
        .ext_mem_r_addr_o (ext_mem_r_addr),
        .ext_mem_r_data_i (ext_mem_r_data),
        .r_data_o         (r_data)
    );

endmodule

// File: tb/tb_iob_fifo_sync_asym.sv
// Bench for iob_fifo_sync_asym: one 32->8 instance (A) and one 8->32
// instance (B), each backed by a behavioural 4-bank registered-read RAM.

module tb_iob_fifo_sync_asym;

    logic clk;
    logic rst;

    // Instance A: W=32, R=8, ADDR_W=4 -> N=4, MINADDR_W=2
    logic [3:0]  a_mw_en;
    logic [7:0]  a_mw_addr;
    logic [31:0] a_mw_data;
    logic        a_mr_en;
    logic [7:0]  a_mr_addr;
    logic [31:0] a_mr_data;
    logic        a_w_en;
    logic [31:0] a_w_data;
    logic        a_w_full;
    logic        a_r_en;
    logic [7:0]  a_r_data;
    logic        a_r_empty;
    logic [4:0]  a_level;

    // Instance B: W=8, R=32, ADDR_W=4 -> N=4, MINADDR_W=2
    logic [3:0]  b_mw_en;
    logic [7:0]  b_mw_addr;
    logic [31:0] b_mw_data;
    logic        b_mr_en;
    logic [7:0]  b_mr_addr;
    logic [31:0] b_mr_data;
    logic        b_w_en;
    logic [7:0]  b_w_data;
    logic        b_w_full;
    logic        b_r_en;
    logic [31:0] b_r_data;
    logic        b_r_empty;
    logic [4:0]  b_level;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem_a [4][4];
    logic [7:0] mem_b [4][4];

    iob_fifo_sync_asym #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) dut_a (
        .clk            (clk),
        .rst            (rst),
        .ext_mem_w_en   (a_mw_en),
        .ext_mem_w_addr (a_mw_addr),
        .ext_mem_w_data (a_mw_data),
        .ext_mem_r_en   (a_mr_en),
        .ext_mem_r_addr (a_mr_addr),
        .ext_mem_r_data (a_mr_data),
        .w_en           (a_w_en),
        .w_data         (a_w_data),
        .w_full         (a_w_full),
        .r_en           (a_r_en),
        .r_data         (a_r_data),
        .r_empty        (a_r_empty),
        .level          (a_level)
    );

    iob_fifo_sync_asym #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) dut_b (
        .clk            (clk),
        .rst            (rst),
        .ext_mem_w_en   (b_mw_en),
        .ext_mem_w_addr (b_mw_addr),
        .ext_mem_w_data (b_mw_data),
        .ext_mem_r_en   (b_mr_en),
        .ext_mem_r_addr (b_mr_addr),
        .ext_mem_r_data (b_mr_data),
        .w_en           (b_w_en),
        .w_data         (b_w_data),
        .w_full         (b_w_full),
        .r_en           (b_r_en),
        .r_data         (b_r_data),
        .r_empty        (b_r_empty),
        .level          (b_level)
    );

    // Behavioural banks: synchronous write, registered read that holds
    // its output while the read enable is low.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (a_mw_en[b]) mem_a[b][a_mw_addr[b*2 +: 2]] <= a_mw_data[b*8 +: 8];
            if (a_mr_en) a_mr_data[b*8 +: 8] <= mem_a[b][a_mr_addr[b*2 +: 2]];
            if (b_mw_en[b]) mem_b[b][b_mw_addr[b*2 +: 2]] <= b_mw_data[b*8 +: 8];
            if (b_mr_en) b_mr_data[b*8 +: 8] <= mem_b[b][b_mr_addr[b*2 +: 2]];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (a_level !== 5'd0) begin errors++; $display("FAIL reset_a_level: got %0d expected 0", a_level); end
        checks++; if (a_r_empty !== 1'b1) begin errors++; $display("FAIL reset_a_r_empty: got %b expected 1", a_r_empty); end
        checks++; if (a_w_full !== 1'b0) begin errors++; $display("FAIL reset_a_w_full: got %b expected 0", a_w_full); end
        checks++; if (a_mw_en !== 4'h0) begin errors++; $display("FAIL reset_a_mem_w_en: got %h expected 0", a_mw_en); end
        checks++; if (a_mr_en !== 1'b0) begin errors++; $display("FAIL reset_a_mem_r_en: got %b expected 0", a_mr_en); end
        checks++; if (b_level !== 5'd0) begin errors++; $display("FAIL reset_b_level: got %0d expected 0", b_level); end
        checks++; if (b_r_empty !== 1'b1) begin errors++; $display("FAIL reset_b_r_empty: got %b expected 1", b_r_empty); end
        checks++; if (b_w_full !== 1'b0) begin errors++; $display("FAIL reset_b_w_full: got %b expected 0", b_w_full); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_wide_write();
        logic [31:0] word;
        word = 32'hDDCCBBAA;
        a_w_data = word;
        a_w_en = 1'b1;
        #1;
        checks++; if (a_mw_en !== 4'hF) begin errors++; $display("FAIL wide_w_bank_en: got %h expected f", a_mw_en); end
        tick();
        a_w_en = 1'b0;
        checks++; if (a_level !== 5'd4) begin errors++; $display("FAIL wide_level_after_write: got %0d expected 4", a_level); end
        checks++; if (a_r_empty !== 1'b0) begin errors++; $display("FAIL wide_r_empty_after_write: got %b expected 0", a_r_empty); end
        for (int i = 0; i < 4; i++) begin
            a_r_en = 1'b1;
            #1;
            checks++; if (a_mr_en !== 1'b1) begin errors++; $display("FAIL wide_mem_r_en[%0d]: got %b expected 1", i, a_mr_en); end
            tick();
            a_r_en = 1'b0;
            checks++; if (a_r_data !== word[i*8 +: 8]) begin errors++; $display("FAIL wide_r_data[%0d]: got %h expected %h", i, a_r_data, word[i*8 +: 8]); end
            checks++; if (a_level !== 5'(3 - i)) begin errors++; $display("FAIL wide_level[%0d]: got %0d expected %0d", i, a_level, 3 - i); end
            checks++; if (a_r_empty !== (i == 3)) begin errors++; $display("FAIL wide_r_empty[%0d]: got %b expected %b", i, a_r_empty, (i == 3)); end
        end
        // Read while empty is dropped; r_data keeps the last byte.
        a_r_en = 1'b1;
        #1;
        checks++; if (a_mr_en !== 1'b0) begin errors++; $display("FAIL empty_read_mem_r_en: got %b expected 0", a_mr_en); end
        tick();
        a_r_en = 1'b0;
        checks++; if (a_level !== 5'd0) begin errors++; $display("FAIL empty_read_level: got %0d expected 0", a_level); end
        checks++; if (a_r_data !== 8'hDD) begin errors++; $display("FAIL empty_read_hold: got %h expected dd", a_r_data); end
    endtask

    task automatic test_narrow_write();
        for (int i = 0; i < 4; i++) begin
            b_w_data = 8'(8'h11 * (i + 1));
            b_w_en = 1'b1;
            #1;
            checks++; if (b_mw_en !== 4'(1 << i)) begin errors++; $display("FAIL narrow_bank_en[%0d]: got %h expected %h", i, b_mw_en, 4'(1 << i)); end
            tick();
            b_w_en = 1'b0;
            checks++; if (b_r_empty !== (i < 3)) begin errors++; $display("FAIL narrow_r_empty[%0d]: got %b expected %b", i, b_r_empty, (i < 3)); end
            checks++; if (b_level !== 5'(i + 1)) begin errors++; $display("FAIL narrow_level[%0d]: got %0d expected %0d", i, b_level, i + 1); end
        end
        b_r_en = 1'b1;
        tick();
        b_r_en = 1'b0;
        checks++; if (b_r_data !== 32'h44332211) begin errors++; $display("FAIL narrow_r_data: got %h expected 44332211", b_r_data); end
        checks++; if (b_level !== 5'd0) begin errors++; $display("FAIL narrow_level_end: got %0d expected 0", b_level); end
        checks++; if (b_r_empty !== 1'b1) begin errors++; $display("FAIL narrow_r_empty_end: got %b expected 1", b_r_empty); end
    endtask

    task automatic test_full();
        for (int w = 0; w < 4; w++) begin
            a_w_data = {8'(4*w + 3), 8'(4*w + 2), 8'(4*w + 1), 8'(4*w)};
            a_w_en = 1'b1;
            tick();
            a_w_en = 1'b0;
            checks++; if (a_level !== 5'(4*(w + 1))) begin errors++; $display("FAIL full_level[%0d]: got %0d expected %0d", w, a_level, 4*(w + 1)); end
            checks++; if (a_w_full !== (w == 3)) begin errors++; $display("FAIL full_flag[%0d]: got %b expected %b", w, a_w_full, (w == 3)); end
        end
        // Write on full is dropped.
        a_w_data = 32'hFFFFFFFF;
        a_w_en = 1'b1;
        #1;
        checks++; if (a_mw_en !== 4'h0) begin errors++; $display("FAIL full_drop_mem_w_en: got %h expected 0", a_mw_en); end
        tick();
        a_w_en = 1'b0;
        checks++; if (a_level !== 5'd16) begin errors++; $display("FAIL full_drop_level: got %0d expected 16", a_level); end
        for (int i = 0; i < 16; i++) begin
            a_r_en = 1'b1;
            tick();
            a_r_en = 1'b0;
            checks++; if (a_r_data !== 8'(i)) begin errors++; $display("FAIL full_r_data[%0d]: got %h expected %h", i, a_r_data, 8'(i)); end
            checks++; if (a_w_full !== ((15 - i) > 12)) begin errors++; $display("FAIL full_flag_drain[%0d]: got %b expected %b", i, a_w_full, ((15 - i) > 12)); end
        end
        checks++; if (a_r_empty !== 1'b1) begin errors++; $display("FAIL full_r_empty_end: got %b expected 1", a_r_empty); end
    endtask

    task automatic test_simultaneous();
        a_w_data = 32'h13121110; a_w_en = 1'b1; tick();
        a_w_data = 32'h17161514; tick();
        a_w_en = 1'b0;
        checks++; if (a_level !== 5'd8) begin errors++; $display("FAIL simul_level_pre: got %0d expected 8", a_level); end
        // w_ptr is 3 here (1 after earlier tests, plus 2 writes).
        checks++; if (a_mw_addr !== 8'hFF) begin errors++; $display("FAIL simul_w_addr_pre: got %h expected ff", a_mw_addr); end
        a_w_data = 32'h1B1A1918;
        a_w_en = 1'b1;
        a_r_en = 1'b1;
        tick();
        a_w_en = 1'b0;
        a_r_en = 1'b0;
        checks++; if (a_level !== 5'd11) begin errors++; $display("FAIL simul_level: got %0d expected 11", a_level); end
        checks++; if (a_r_data !== 8'h10) begin errors++; $display("FAIL simul_r_data: got %h expected 10", a_r_data); end
        checks++; if (a_mw_addr !== 8'h00) begin errors++; $display("FAIL simul_w_addr_post: got %h expected 00", a_mw_addr); end
        checks++; if (a_w_full !== 1'b0) begin errors++; $display("FAIL simul_w_full: got %b expected 0", a_w_full); end
        for (int i = 0; i < 11; i++) begin
            a_r_en = 1'b1;
            tick();
            a_r_en = 1'b0;
            checks++; if (a_r_data !== 8'(8'h11 + i)) begin errors++; $display("FAIL simul_drain[%0d]: got %h expected %h", i, a_r_data, 8'(8'h11 + i)); end
        end
        checks++; if (a_r_empty !== 1'b1) begin errors++; $display("FAIL simul_r_empty_end: got %b expected 1", a_r_empty); end
    endtask

    task automatic test_wrap();
        logic [7:0] base;
        for (int r = 0; r < 10; r++) begin
            base = 8'(8'h40 + 4*r);
            a_w_data = {8'(base + 3), 8'(base + 2), 8'(base + 1), base};
            a_w_en = 1'b1;
            tick();
            a_w_en = 1'b0;
            checks++; if (a_level !== 5'd4 || a_w_full !== 1'b0 || a_r_empty !== 1'b0) begin
                errors++; $display("FAIL wrap_flags[%0d]: got level=%0d full=%b empty=%b expected 4/0/0", r, a_level, a_w_full, a_r_empty);
            end
            for (int i = 0; i < 4; i++) begin
                a_r_en = 1'b1;
                tick();
                a_r_en = 1'b0;
                checks++; if (a_r_data !== 8'(base + i)) begin errors++; $display("FAIL wrap_r_data[%0d][%0d]: got %h expected %h", r, i, a_r_data, 8'(base + i)); end
            end
            checks++; if (a_r_empty !== 1'b1) begin errors++; $display("FAIL wrap_r_empty[%0d]: got %b expected 1", r, a_r_empty); end
        end
    endtask

    task automatic test_reset_mid();
        for (int w = 0; w < 3; w++) begin
            a_w_data = 32'hC0C0C0C0 + 32'(w);
            a_w_en = 1'b1;
            tick();
        end
        a_w_en = 1'b0;
        checks++; if (a_level !== 5'd12) begin errors++; $display("FAIL rstmid_level_pre: got %0d expected 12", a_level); end
        checks++; if (a_w_full !== 1'b0) begin errors++; $display("FAIL rstmid_w_full_pre: got %b expected 0", a_w_full); end
        // Assert reset between clock edges: the clear must not wait for clk.
        #2;
        rst = 1'b1;
        #1;
        checks++; if (a_level !== 5'd0) begin errors++; $display("FAIL rstmid_level: got %0d expected 0", a_level); end
        checks++; if (a_r_empty !== 1'b1) begin errors++; $display("FAIL rstmid_r_empty: got %b expected 1", a_r_empty); end
        checks++; if (a_w_full !== 1'b0) begin errors++; $display("FAIL rstmid_w_full: got %b expected 0", a_w_full); end
        rst = 1'b0;
        tick();
        a_w_data = 32'hA3A2A1A0;
        a_w_en = 1'b1;
        tick();
        a_w_en = 1'b0;
        checks++; if (a_level !== 5'd4) begin errors++; $display("FAIL rstmid_level_fresh: got %0d expected 4", a_level); end
        for (int i = 0; i < 4; i++) begin
            a_r_en = 1'b1;
            tick();
            a_r_en = 1'b0;
            checks++; if (a_r_data !== 8'(8'hA0 + i)) begin errors++; $display("FAIL rstmid_r_data[%0d]: got %h expected %h", i, a_r_data, 8'(8'hA0 + i)); end
        end
    endtask

    initial begin
        rst = 1'b1;
        a_w_en = 1'b0; a_w_data = '0; a_r_en = 1'b0;
        b_w_en = 1'b0; b_w_data = '0; b_r_en = 1'b0;
        test_reset();
        test_wide_write();
        test_narrow_write();
        test_full();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/iob_fifo_sync_asym.md
Name: iob_fifo_sync_asym

Overview:
Single-clock FIFO with independent write and read data widths (either ratio, or equal), built on external dual-port RAM banks.
- Storage is N = MAXDATA_W/MINDATA_W banks of MINDATA_W x 2^MINADDR_W, exposed on ext_mem_* ports so the memory macro stays outside (wrapper or testbench).
- Converts wide-to-narrow or narrow-to-wide streams (e.g. 32-bit bus to 8-bit UART stream) with occupancy tracking in minimum-width units.

Parameters:
- W_DATA_W, 32, write word width; must be MINDATA_W times a power of two.
- R_DATA_W, 8, read word width; same constraint.
- ADDR_W, 4, log2 of total capacity in MINDATA_W units.
- MAXDATA_W, max(W_DATA_W,R_DATA_W), derived.
- MINDATA_W, min(W_DATA_W,R_DATA_W), derived.
- N, MAXDATA_W/MINDATA_W, derived bank count.
- MINADDR_W, ADDR_W-log2(N), derived bank address width.
- W_ADDR_W, MINADDR_W if W_DATA_W==MAXDATA_W else ADDR_W, derived.
- R_ADDR_W, MINADDR_W if R_DATA_W==MAXDATA_W else ADDR_W, derived.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ext_mem_w_en  out  N  per-bank write enable
- ext_mem_w_addr  out  N*MINADDR_W  per-bank write address
- ext_mem_w_data  out  N*MINDATA_W  per-bank write data
- ext_mem_r_en  out  1  read enable, all banks
- ext_mem_r_addr  out  N*MINADDR_W  per-bank read address
- ext_mem_r_data  in  N*MINDATA_W  per-bank read data, registered one cycle after r_en
- w_en  in  1  write request
- w_data  in  W_DATA_W  write word
- w_full  out  1  no room for one more W word
- r_en  in  1  read request
- r_data  out  R_DATA_W  read word, valid the cycle after an accepted read
- r_empty  out  1  fewer than one R word stored
- level  out  ADDR_W+1  occupancy in MINDATA_W units

Behaviour:
- Reset (async assert, sync release): w_ptr=0, r_ptr=0, level=0, w_full=0, r_empty=1; ext_mem_w_en=0, ext_mem_r_en=0; r_data lane-select register cleared. RAM contents undefined.
- Accepted write: w_en & ~w_full. Accepted read: r_en & ~r_empty. Rejected requests are dropped: no pointer, level or RAM effect, and no error flag.
- Write pointer W_ADDR_W bits and read pointer R_ADDR_W bits, each incremented by 1 per accepted op. Both wrap modulo 2^W_ADDR_W / 2^R_ADDR_W.
- Write wider than read: all N banks are written in parallel at w_ptr, lane j getting w_data[j*MINDATA_W +: MINDATA_W].
  - Every bank reads at r_ptr[R_ADDR_W-1 -: MINADDR_W].
  - r_ptr LSBs are registered on the accepted read; that register selects the bank for r_data. Lane 0 is read first (little-endian).
- Write narrower than read: only bank w_ptr[log2(N)-1:0] is enabled, at address w_ptr[W_ADDR_W-1 -: MINADDR_W]. All banks read at r_ptr; r_data concatenates banks with bank 0 in the LSBs.
- Equal widths: N=1, direct mapping.
- ext_mem_r_en = accepted read only (not raw r_en). ext_mem_w_en is gated by acceptance.
- Level update per cycle: level_next = level + (acc_w ? W_DATA_W/MINDATA_W : 0) - (acc_r ? R_DATA_W/MINDATA_W : 0).
  - Simultaneous write and read both apply in the same cycle.
  - level never exceeds 2^ADDR_W and never goes negative.
- Flags are registered from level_next:
  - w_full = level_next > 2^ADDR_W - W_DATA_W/MINDATA_W
  - r_empty = level_next < R_DATA_W/MINDATA_W
- Read latency: r_data valid exactly 1 cycle after an accepted read. It holds its value until the next accepted read (bank output hold plus held select).
- Write-to-read latency: data written in cycle t is readable from cycle t+1, since r_empty drops at t+1. The RAM must be write-first or the read must not hit the same address in the same cycle; the pointer discipline guarantees the latter.
- Reset asserted mid-transfer: FIFO empties immediately; an in-flight r_data is discarded.

Decomposition:
- Shared package/header: `IOB_MAX`, `IOB_MIN` macros and the derived-width expressions for reuse by the wrapper and the bench.
- One sub-module: iob_ram_2p_asym handles bank mapping (write/read address split, lane mux).
- This block adds pointers, level, flags and acceptance gating around that sub-module.

Test Plan:
- W=32,R=8,ADDR_W=4: write 0xDDCCBBAA, then 4 reads -> r_data 0xAA,0xBB,0xCC,0xDD; r_empty=1 after the 4th read; level 4→0.
- W=8,R=32: write 0x11,0x22,0x33,0x44 -> r_empty drops after the 4th write; one read gives 0x44332211; level returns to 0.
- W=32,R=8: 4 writes -> level=16, w_full=1; a 5th write is ignored (level stays 16), and all 16 bytes are read in order.
- Simultaneous: at level=8 (W=32,R=8), w_en and r_en in the same cycle -> level=11, both pointers advance.
- Wrap: 10 write/read rounds of 4 bytes each -> data stays in order across the pointer wrap, with no spurious full or empty.
- rst pulsed while level=12 -> asynchronously level=0, r_empty=1, w_full=0; the next write/read pair returns fresh data.
